// File: rtl/execute_stage_param.sv
// rtl/execute_stage_param.sv - execute stage: forwarding, CZN flags, jump condition, I/O ports, iterative multiply
module execute_stage_param #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int CNT_W      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            alu_op,
   input  logic [REG_ADDR_W-1:0] src1_addr,
   input  logic [REG_ADDR_W-1:0] src2_addr,
   input  logic [DATA_W-1:0]     rf_data1,
   input  logic [DATA_W-1:0]     rf_data2,
   input  logic [DATA_W-1:0]     imm,
   input  logic                  alu_src,
   input  logic                  fwd_mem_en,
   input  logic [REG_ADDR_W-1:0] fwd_mem_addr,
   input  logic [DATA_W-1:0]     fwd_mem_data,
   input  logic                  fwd_wb_en,
   input  logic [REG_ADDR_W-1:0] fwd_wb_addr,
   input  logic [DATA_W-1:0]     fwd_wb_data,
   input  logic [1:0]            jump_type,
   input  logic                  flags_restore,
   input  logic [2:0]            flags_restore_data,
   input  logic [DATA_W-1:0]     in_port,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     result,
   output logic [DATA_W-1:0]     result_hi,
   output logic [2:0]            flags,
   output logic                  jump_taken,
   output logic [DATA_W-1:0]     out_port
);

   localparam logic S_IDLE = 1'b0;
   localparam logic S_MUL  = 1'b1;

   localparam logic [3:0] OP_NOP = 4'd0, OP_NOT = 4'd1, OP_INC = 4'd2, OP_DEC = 4'd3,
                          OP_ADD = 4'd4, OP_SUB = 4'd5, OP_AND = 4'd6, OP_OR  = 4'd7,
                          OP_SHL = 4'd8, OP_SHR = 4'd9, OP_MOV = 4'd10, OP_MUL = 4'd11,
                          OP_SETC = 4'd12, OP_CLRC = 4'd13, OP_IN = 4'd14, OP_OUT = 4'd15;

   localparam logic [DATA_W:0]  ONE_W   = (DATA_W+1)'(1);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DATA_W-1);

   logic                  state;
   logic [CNT_W-1:0]      cnt;
   logic [2*DATA_W-1:0]   mcand;
   logic [2*DATA_W-1:0]   acc;
   logic [DATA_W-1:0]     mplier;
   logic [2*DATA_W-1:0]   step_acc;

   logic                  accept;
   logic [DATA_W-1:0]     op1, op2;
   logic [DATA_W-1:0]     alu_res;
   logic [DATA_W:0]       wide;
   logic                  c_new, upd_c, upd_zn;
   logic [2:0]            flags_next;
   logic                  jcond;
   logic [3:0]            shamt;

   assign accept   = in_valid & in_ready;
   assign shamt    = imm[3:0];
   assign step_acc = acc + (mplier[0] ? mcand : '0);

   // Memory-stage result is younger than write-back, so it wins the forward.
   always_comb begin
      op1 = rf_data1;
      if (fwd_mem_en && fwd_mem_addr == src1_addr)      op1 = fwd_mem_data;
      else if (fwd_wb_en && fwd_wb_addr == src1_addr)   op1 = fwd_wb_data;
      op2 = rf_data2;
      if (alu_src)                                      op2 = imm;
      else if (fwd_mem_en && fwd_mem_addr == src2_addr) op2 = fwd_mem_data;
      else if (fwd_wb_en && fwd_wb_addr == src2_addr)   op2 = fwd_wb_data;
   end

   always_comb begin
      alu_res = '0;
      wide    = '0;
      c_new   = flags[2];
      upd_c   = 1'b0;
      upd_zn  = 1'b0;
      case (alu_op)
         OP_NOT: begin alu_res = ~op1; upd_zn = 1'b1; end
         OP_INC, OP_DEC, OP_ADD, OP_SUB: begin
            case (alu_op)
               OP_INC:  wide = {1'b0, op1} + ONE_W;
               OP_DEC:  wide = {1'b0, op1} - ONE_W;
               OP_ADD:  wide = {1'b0, op1} + {1'b0, op2};
               default: wide = {1'b0, op1} - {1'b0, op2};
            endcase
            alu_res = wide[DATA_W-1:0];
            c_new   = wide[DATA_W];
            upd_c   = 1'b1;
            upd_zn  = 1'b1;
         end
         OP_AND: begin alu_res = op1 & op2; upd_zn = 1'b1; end
         OP_OR:  begin alu_res = op1 | op2; upd_zn = 1'b1; end
         // Shifts go through one spare bit so the last bit shifted out lands in it.
         OP_SHL: begin
            wide    = {1'b0, op1} << shamt;
            alu_res = wide[DATA_W-1:0];
            c_new   = (shamt == 4'd0) ? flags[2] : wide[DATA_W];
            upd_c   = 1'b1;
            upd_zn  = 1'b1;
         end
         OP_SHR: begin
            wide    = {op1, 1'b0} >> shamt;
            alu_res = wide[DATA_W:1];
            c_new   = (shamt == 4'd0) ? flags[2] : wide[0];
            upd_c   = 1'b1;
            upd_zn  = 1'b1;
         end
         OP_MOV, OP_OUT: alu_res = op1;
         OP_IN:          alu_res = in_port;
         OP_SETC: begin c_new = 1'b1; upd_c = 1'b1; end
         OP_CLRC: begin c_new = 1'b0; upd_c = 1'b1; end
         default: alu_res = '0;
      endcase
      flags_next[2] = upd_c  ? c_new : flags[2];
      flags_next[1] = upd_zn ? (alu_res == '0) : flags[1];
      flags_next[0] = upd_zn ? alu_res[DATA_W-1] : flags[0];
   end

   always_comb begin
      case (jump_type)
         2'd1:    jcond = flags[1];
         2'd2:    jcond = flags[0];
         2'd3:    jcond = flags[2];
         default: jcond = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         in_ready   <= 1'b0;
         cnt        <= '0;
         mcand      <= '0;
         acc        <= '0;
         mplier     <= '0;
         out_valid  <= 1'b0;
         result     <= '0;
         result_hi  <= '0;
         flags      <= 3'b000;
         jump_taken <= 1'b0;
         out_port   <= '0;
      end else begin
         out_valid  <= 1'b0;
         jump_taken <= accept & jcond;
         if (flags_restore)
            flags <= flags_restore_data;
         case (state)
            S_IDLE: begin
               in_ready <= 1'b1;
               if (accept && alu_op == OP_MUL) begin
                  state    <= S_MUL;
                  in_ready <= 1'b0;
                  cnt      <= '0;
                  mcand    <= {{DATA_W{1'b0}}, op1};
                  mplier   <= op2;
                  acc      <= '0;
               end else if (accept) begin
                  out_valid <= 1'b1;
                  result    <= alu_res;
                  result_hi <= '0;
                  if (!flags_restore)
                     flags <= flags_next;
                  if (alu_op == OP_OUT)
                     out_port <= op1;
               end
            end
            default: begin
               acc    <= step_acc;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == CNT_END) begin
                  state     <= S_IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b1;
                  result    <= step_acc[DATA_W-1:0];
                  result_hi <= step_acc[2*DATA_W-1:DATA_W];
                  if (!flags_restore)
                     flags <= {1'b0, step_acc == '0, step_acc[2*DATA_W-1]};
               end
            end
         endcase
      end
   end

endmodule
